// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, the key map and a row priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // Indexed [row][col]; '*' reports as E and '#' as F.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest row reading 0; only called when at least one row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    lowest_low = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) lowest_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to RST_VAL so idle (pulled-up) lines read as inactive.
module sync_2ff #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             int_osc,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-key press/release debounce.
// Rotates an active-low column drive on each scan tick and freezes it while a key is tracked.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 24000,
  parameter int DB_TICKS = 20
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_TICKS - 1);
  // Release leaves once the incremented count would reach DB_TICKS-1.
  localparam logic [DW-1:0] REL_LAST  = DW'((DB_TICKS >= 2) ? DB_TICKS - 2 : 0);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    rows_sync;
  state_t        state;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [DW-1:0] db_cnt;
  logic          row_low;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'b1111)) u_rows_sync (
    .int_osc (int_osc),
    .reset   (reset),
    .d       (rows),
    .q       (rows_sync)
  );

  assign tick    = (tick_cnt == TICK_LAST);
  assign row_low = ~rows_sync[row_idx];

  // Free-running scan timebase, never restarted by the FSM.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      cols      <= 4'b1110;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      db_cnt    <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (rows_sync == 4'b1111) begin
              cols    <= {cols[2:0], cols[3]};
              col_idx <= col_idx + 1'b1;
            end else begin
              row_idx <= lowest_low(rows_sync);
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!row_low) begin
              state   <= SCAN;
              cols    <= {cols[2:0], cols[3]};
              col_idx <= col_idx + 1'b1;
            end else if (db_cnt == DB_LAST) begin
              state     <= HELD;
              key       <= KEYMAP[row_idx][col_idx];
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          HELD: begin
            if (!row_low) begin
              db_cnt <= '0;
              state  <= RELEASE;
            end
          end
          RELEASE: begin
            if (row_low) begin
              state <= HELD;
            end else if (db_cnt >= REL_LAST) begin
              state    <= SCAN;
              key_held <= 1'b0;
              cols     <= {cols[2:0], cols[3]};
              col_idx  <= col_idx + 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
